// File: rtl/moore_sequence_generator.sv
// Serial MSB-first pattern transmitter feeding the Moore sequence detector.
// Optional build macro GEN_PRBS_FILL_EN drives PRBS-7 fill onto x_out during GAP cycles.
module moore_sequence_generator #(
  parameter int PAT_W = 4,
  parameter int LEN_W = 3,
  parameter int REP_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic [LEN_W-1:0] pat_len,
  input  logic [REP_W-1:0] rep_cnt,
  input  logic [GAP_W-1:0] gap_len,
  input  logic             abort,
  output logic             x_out,
  output logic             x_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE = 3'b000,
    SEND = 3'b001,
    GAP  = 3'b010,
    DONE = 3'b100
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);
  localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [GAP_W-1:0] gcnt_q, gcnt_d;
  logic             x_out_q, x_out_d;
  logic             x_valid_q, x_valid_d;
  logic             fs_q, fs_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;
  logic             gap_fill;
  logic [LEN_W-1:0] eff_l;

  // Zero or oversized lengths fall back to the full pattern width.
  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
    if ((len == '0) || (len > LEN_W'(PAT_W))) return LEN_W'(PAT_W);
    return len;
  endfunction

  function automatic logic bit_at(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] i);
    logic [PAT_W-1:0] s;
    s = p >> i;
    return s[0];
  endfunction

  assign start_ready = (state_q == IDLE) && !abort;
  assign accept      = start_valid && start_ready;
  assign eff_l       = eff_len(pat_len);

`ifdef GEN_PRBS_FILL_EN
  logic [6:0] lfsr_q, lfsr_d;

  assign gap_fill = lfsr_q[6];

  // x^7 + x^6 + 1, stepped only on cycles that will be spent in GAP.
  always_comb begin
    lfsr_d = lfsr_q;
    if (state_d == GAP) lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= 7'h01;
    else      lfsr_q <= lfsr_d;
  end
`else
  assign gap_fill = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    len_d     = len_q;
    gap_d     = gap_q;
    rep_d     = rep_q;
    idx_d     = idx_q;
    gcnt_d    = gcnt_q;
    x_out_d   = 1'b0;
    x_valid_d = 1'b0;
    fs_d      = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          pat_d = pattern_in;
          len_d = eff_l;
          gap_d = gap_len;
          if (rep_cnt != '0) begin
            state_d   = SEND;
            rep_d     = rep_cnt - REP_ONE;
            idx_d     = eff_l - LEN_ONE;
            x_out_d   = bit_at(pattern_in, eff_l - LEN_ONE);
            x_valid_d = 1'b1;
            fs_d      = 1'b1;
            busy_d    = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      SEND: begin
        if (idx_q != '0) begin
          idx_d     = idx_q - LEN_ONE;
          x_out_d   = bit_at(pat_q, idx_q - LEN_ONE);
          x_valid_d = 1'b1;
          busy_d    = 1'b1;
        end else if (rep_q != '0) begin
          rep_d  = rep_q - REP_ONE;
          busy_d = 1'b1;
          if (gap_q != '0) begin
            state_d = GAP;
            gcnt_d  = gap_q - GAP_ONE;
            x_out_d = gap_fill;
          end else begin
            // Back-to-back repetition: reload without a bubble cycle.
            idx_d     = len_q - LEN_ONE;
            x_out_d   = bit_at(pat_q, len_q - LEN_ONE);
            x_valid_d = 1'b1;
            fs_d      = 1'b1;
          end
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      GAP: begin
        busy_d = 1'b1;
        if (gcnt_q != '0) begin
          gcnt_d  = gcnt_q - GAP_ONE;
          x_out_d = gap_fill;
        end else begin
          state_d   = SEND;
          idx_d     = len_q - LEN_ONE;
          x_out_d   = bit_at(pat_q, len_q - LEN_ONE);
          x_valid_d = 1'b1;
          fs_d      = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Cancel wins over every transition; the transfer ends silently.
    if (abort) begin
      state_d   = IDLE;
      x_out_d   = 1'b0;
      x_valid_d = 1'b0;
      fs_d      = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      rep_q     <= '0;
      idx_q     <= '0;
      gcnt_q    <= '0;
      x_out_q   <= 1'b0;
      x_valid_q <= 1'b0;
      fs_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rep_q     <= rep_d;
      idx_q     <= idx_d;
      gcnt_q    <= gcnt_d;
      x_out_q   <= x_out_d;
      x_valid_q <= x_valid_d;
      fs_q      <= fs_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Transfer parameters are only meaningful while a transfer is active.
  always_ff @(posedge clk) begin
    pat_q <= pat_d;
    len_q <= len_d;
    gap_q <= gap_d;
  end

  assign x_out       = x_out_q;
  assign x_valid     = x_valid_q;
  assign frame_start = fs_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_moore_sequence_generator.sv
// Bench for moore_sequence_generator: directed cases plus randomized traffic against a queue model.
module tb_moore_sequence_generator;
  localparam int PAT_W = 4;
  localparam int LEN_W = 3;
  localparam int REP_W = 8;
  localparam int GAP_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_valid;
  logic             start_ready;
  logic [PAT_W-1:0] pattern_in;
  logic [LEN_W-1:0] pat_len;
  logic [REP_W-1:0] rep_cnt;
  logic [GAP_W-1:0] gap_len;
  logic             abort;
  logic             x_out, x_valid, frame_start, busy, done;

  moore_sequence_generator #(
    .PAT_W(PAT_W), .LEN_W(LEN_W), .REP_W(REP_W), .GAP_W(GAP_W)
  ) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .pattern_in(pattern_in), .pat_len(pat_len), .rep_cnt(rep_cnt), .gap_len(gap_len),
    .abort(abort), .x_out(x_out), .x_valid(x_valid), .frame_start(frame_start),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic v;
    logic x;
    logic fs;
    logic busy;
    logic done;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit model_idle();
    return (q.size() == 0) && !cur.done;
  endfunction

  // Expected per-cycle output stream for one accepted request.
  task automatic build(input logic [3:0] p, input logic [2:0] len, input logic [7:0] r,
                       input logic [3:0] g);
    int L;
    L = ((len == 0) || (int'(len) > PAT_W)) ? PAT_W : int'(len);
    q.delete();
    for (int i = 0; i < int'(r); i++) begin
      for (int b = L - 1; b >= 0; b--)
        q.push_back(exp_t'{v: 1'b1, x: p[b], fs: (b == L - 1), busy: 1'b1, done: 1'b0});
      if (i < int'(r) - 1)
        for (int k = 0; k < int'(g); k++)
          q.push_back(exp_t'{v: 1'b0, x: 1'b0, fs: 1'b0, busy: 1'b1, done: 1'b0});
    end
    q.push_back(exp_t'{v: 1'b0, x: 1'b0, fs: 1'b0, busy: 1'b0, done: 1'b1});
  endtask

  task automatic check_outs();
    chk_eq("x_valid", 32'(x_valid), 32'(cur.v));
    chk_eq("x_out", 32'(x_out), 32'(cur.x));
    chk_eq("frame_start", 32'(frame_start), 32'(cur.fs));
    chk_eq("busy", 32'(busy), 32'(cur.busy));
    chk_eq("done", 32'(done), 32'(cur.done));
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic cycle();
    logic acc;
    #2;
    chk_eq("start_ready", 32'(start_ready), 32'(model_idle() && !abort));
    acc = start_valid && model_idle() && !abort;
    @(posedge clk);
    if (abort) begin
      q.delete();
      cur = '0;
    end else begin
      if (acc) build(pattern_in, pat_len, rep_cnt, gap_len);
      if (q.size() > 0) cur = q.pop_front();
      else cur = '0;
    end
    #1;
    check_outs();
  endtask

  task automatic run_tx(input logic [3:0] p, input logic [2:0] len, input logic [7:0] r,
                        input logic [3:0] g);
    int L, lat, exp_lat, k;
    L = ((len == 0) || (int'(len) > PAT_W)) ? PAT_W : int'(len);
    exp_lat = (r == 0) ? 1 : int'(r) * L + (int'(r) - 1) * int'(g) + 1;
    pattern_in = p; pat_len = len; rep_cnt = r; gap_len = g;
    start_valid = 1'b1;
    cycle();
    start_valid = 1'b0;
    // Later input changes must not disturb the transfer.
    pattern_in = 4'($urandom); pat_len = 3'($urandom); rep_cnt = 8'($urandom); gap_len = 4'($urandom);
    lat = (done === 1'b1) ? 1 : -1;
    k = 1;
    while (!model_idle() && k < 300) begin
      cycle();
      k++;
      if (done === 1'b1 && lat < 0) lat = k;
    end
    chk_eq("tx_timeout", 32'(model_idle()), 32'd1);
    chk_eq("done_latency", 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    rst = 1'b0; start_valid = 1'b0; abort = 1'b0;
    pattern_in = '0; pat_len = '0; rep_cnt = '0; gap_len = '0;
    cur = '0;
    repeat (2) @(posedge clk);
    #1;
    check_outs();
    chk_eq("reset_ready", 32'(start_ready), 32'd1);
    rst = 1'b1;

    run_tx(4'b1001, 3'd4, 8'd1, 4'd0);
    run_tx(4'b1001, 3'd4, 8'd3, 4'd0);
    run_tx(4'b1001, 3'd4, 8'd2, 4'd2);
    run_tx(4'b1001, 3'd4, 8'd0, 4'd3);
    run_tx(4'b1001, 3'd0, 8'd1, 4'd0);
    run_tx(4'b1011, 3'd7, 8'd2, 4'd1);
    run_tx(4'b0110, 3'd2, 8'd3, 4'd1);
    run_tx(4'b1111, 3'd1, 8'd4, 4'd0);

    // Abort while the second bit is on the wire.
    pattern_in = 4'b1001; pat_len = 3'd4; rep_cnt = 8'd2; gap_len = 4'd0;
    start_valid = 1'b1;
    cycle();
    start_valid = 1'b0;
    cycle();
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    repeat (6) cycle();

    // Abort in IDLE blocks accept.
    abort = 1'b1; start_valid = 1'b1;
    cycle();
    abort = 1'b0; start_valid = 1'b0;
    cycle();

    // start_valid held while busy is not queued.
    pattern_in = 4'b1001; pat_len = 3'd4; rep_cnt = 8'd1; gap_len = 4'd0;
    start_valid = 1'b1;
    repeat (4) cycle();
    start_valid = 1'b0;
    repeat (8) cycle();

    // Asynchronous reset in the middle of SEND.
    pattern_in = 4'b1001; pat_len = 3'd4; rep_cnt = 8'd3; gap_len = 4'd1;
    start_valid = 1'b1;
    cycle();
    start_valid = 1'b0;
    cycle();
    #2 rst = 1'b0;
    #1;
    q.delete();
    cur = '0;
    check_outs();
    @(posedge clk);
    #1;
    check_outs();
    rst = 1'b1;
    run_tx(4'b1001, 3'd4, 8'd1, 4'd0);

    for (int t = 0; t < 80; t++) begin
      int k;
      pattern_in  = 4'($urandom);
      pat_len     = 3'($urandom_range(0, 7));
      rep_cnt     = 8'($urandom_range(0, 4));
      gap_len     = 4'($urandom_range(0, 3));
      abort       = ($urandom_range(0, 19) == 0);
      start_valid = 1'b1;
      cycle();
      k = 0;
      while (!model_idle() && k < 300) begin
        pattern_in  = 4'($urandom);
        pat_len     = 3'($urandom);
        rep_cnt     = 8'($urandom_range(0, 4));
        gap_len     = 4'($urandom_range(0, 3));
        start_valid = 1'($urandom_range(0, 1));
        abort       = ($urandom_range(0, 29) == 0);
        cycle();
        k++;
      end
      chk_eq("rand_timeout", 32'(model_idle()), 32'd1);
      abort = 1'b0;
      start_valid = 1'b0;
    end
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
